// File: rtl/result_drain_pkg.sv
// Shared configuration, FSM state type and row slicing helper for the results drain.
package result_drain_pkg;

   localparam int unsigned ADDRESSSIZE    = 10;
   localparam int unsigned PARTIAL_SUM_BW = 24;
   localparam int unsigned MATRIX_SIZE    = 64;
   localparam int unsigned LANES          = 8;

   localparam int unsigned ROW_W      = PARTIAL_SUM_BW * MATRIX_SIZE;
   localparam int unsigned BEAT_W     = PARTIAL_SUM_BW * LANES;
   localparam int unsigned BEATS      = MATRIX_SIZE / LANES;
   localparam int unsigned BEAT_IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned CNT_W      = ADDRESSSIZE + 1;
   localparam int unsigned ROW_IDX_W  = $clog2(ROW_W);

   typedef enum logic [2:0] {
      IDLE,
      RD,
      CAP,
      SEND,
      DONE
   } state_e;

   // Beat k of a row: lanes k*LANES .. k*LANES+LANES-1, lane 0 in the LSBs.
   function automatic logic [BEAT_W-1:0] beat_slice(input logic [ROW_W-1:0]      row,
                                                    input logic [BEAT_IDX_W-1:0] k);
      return row[ROW_IDX_W'(k) * ROW_IDX_W'(BEAT_W) +: BEAT_W];
   endfunction

endpackage

// File: rtl/row_serializer.sv
// Holds one captured results row and presents it one registered beat at a time.
module row_serializer
   import result_drain_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic              advance_i,
   input  logic [ROW_W-1:0]  row_i,
   output logic [BEAT_W-1:0] data_o,
   output logic              last_beat_o
);

   localparam logic [BEAT_IDX_W-1:0] LAST_IDX = BEAT_IDX_W'(BEATS - 1);

   logic [ROW_W-1:0]      row_q, row_d;
   logic [BEAT_IDX_W-1:0] idx_q, idx_d;
   logic [BEAT_W-1:0]     data_q, data_d;
   logic                  last_q, last_d;

   // Row, beat index and the presented beat are all registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_q  <= '0;
         idx_q  <= '0;
         data_q <= '0;
         last_q <= 1'b0;
      end else begin
         row_q  <= row_d;
         idx_q  <= idx_d;
         data_q <= data_d;
         last_q <= last_d;
      end
   end

   // Load starts a row at beat 0; advance steps to the next beat and wraps after the last.
   always_comb begin
      row_d  = row_q;
      idx_d  = idx_q;
      data_d = data_q;
      last_d = last_q;
      if (load_i) begin
         row_d  = row_i;
         idx_d  = '0;
         data_d = beat_slice(row_i, '0);
         last_d = (LAST_IDX == '0);
      end else if (advance_i) begin
         idx_d  = (idx_q == LAST_IDX) ? '0 : idx_q + BEAT_IDX_W'(1);
         data_d = beat_slice(row_q, idx_d);
         last_d = (idx_d == LAST_IDX);
      end
   end

   assign data_o      = data_q;
   assign last_beat_o = last_q;

endmodule

// File: rtl/result_readback_drain.sv
// Reads a run of results rows from the SRAM and streams them out as valid/ready beats.
module result_readback_drain
   import result_drain_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [ADDRESSSIZE-1:0] base_addr,
   input  logic [CNT_W-1:0]       row_count,
   input  logic                   sram_wr_active,
   output logic                   sram_rd_en,
   output logic [ADDRESSSIZE-1:0] sram_rd_addr,
   input  logic [ROW_W-1:0]       sram_rd_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [BEAT_W-1:0]      out_data,
   output logic                   out_last_beat,
   output logic                   out_last_row,
   output logic                   busy,
   output logic                   done
);

   state_e                 state_q, state_d;
   logic [ADDRESSSIZE-1:0] base_q, base_d;
   logic [ADDRESSSIZE-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic [CNT_W-1:0]       row_idx_q, row_idx_d;
   logic                   valid_q, valid_d;
   logic                   last_row_q, last_row_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   rd_en_c;
   logic                   load_c;
   logic                   advance_c;
   logic                   beat_last;

   // State, counters and registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         base_q     <= '0;
         addr_q     <= '0;
         count_q    <= '0;
         row_idx_q  <= '0;
         valid_q    <= 1'b0;
         last_row_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         addr_q     <= addr_d;
         count_q    <= count_d;
         row_idx_q  <= row_idx_d;
         valid_q    <= valid_d;
         last_row_q <= last_row_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   // Next state, counter updates, read strobe and next values of the status outputs.
   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      count_d   = count_q;
      row_idx_d = row_idx_q;
      rd_en_c   = 1'b0;
      load_c    = 1'b0;
      advance_c = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (row_count != '0) begin
                  base_d    = base_addr;
                  count_d   = row_count;
                  row_idx_d = '0;
                  state_d   = RD;
               end else begin
                  state_d = DONE;
               end
            end
         end
         RD: begin
            if (!sram_wr_active) begin
               rd_en_c = 1'b1;
               state_d = CAP;
            end
         end
         CAP: begin
            load_c  = 1'b1;
            state_d = SEND;
         end
         SEND: begin
            if (valid_q && out_ready) begin
               advance_c = 1'b1;
               if (beat_last) begin
                  if (row_idx_q == count_q - CNT_W'(1)) begin
                     state_d = DONE;
                  end else begin
                     row_idx_d = row_idx_q + CNT_W'(1);
                     state_d   = RD;
                  end
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Address wraps naturally at the SRAM depth.
      addr_d     = base_d + ADDRESSSIZE'(row_idx_d);
      valid_d    = (state_d == SEND);
      busy_d     = (state_d == RD) || (state_d == CAP) || (state_d == SEND);
      done_d     = (state_d == DONE);
      last_row_d = (state_d == SEND) && (row_idx_d == count_d - CNT_W'(1));
   end

   row_serializer u_serializer (
      .clk         (clk),
      .rst         (rst),
      .load_i      (load_c),
      .advance_i   (advance_c),
      .row_i       (sram_rd_data),
      .data_o      (out_data),
      .last_beat_o (beat_last)
   );

   assign sram_rd_en    = rd_en_c;
   assign sram_rd_addr  = addr_q;
   assign out_valid     = valid_q;
   assign out_last_beat = beat_last;
   assign out_last_row  = last_row_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule
